// File: rtl/weighted_input_sum.sv
// Synaptic front end of the LIF neuron: a shift-loaded bank of signed weights and a
// sequential, per-step saturating accumulator over the active input spikes.
module weighted_input_sum #(
    parameter int n_stage  = 6,
    parameter int n_inputs = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      weight_load,
    input  logic signed [n_stage+1:0] weight_in,
    input  logic                      start,
    input  logic [n_inputs-1:0]       x,
    output logic                      busy,
    output logic                      sum_valid,
    output logic signed [n_stage+1:0] sum_wx
);

    localparam int W  = n_stage + 2;
    localparam int IW = (n_inputs > 1) ? $clog2(n_inputs) : 1;
    localparam logic [IW-1:0]       LAST_IDX = IW'(n_inputs - 1);
    localparam logic signed [W-1:0] MAX_V    = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V    = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } state_t;

    state_t state_q, state_d;

    logic signed [W-1:0] weight [n_inputs];
    logic [n_inputs-1:0] x_lat;
    logic [IW-1:0]       idx;
    logic signed [W-1:0] acc;
    logic signed [W-1:0] term;
    logic signed [W-1:0] acc_next;
    logic                load_ok;
    logic                start_ok;
    logic                last_step;

    // One guard bit is enough: a sign mismatch between the top two bits means overflow.
    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic signed [W:0] s;
        s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        if (s[W] == s[W-1])
            return s[W-1:0];
        else if (s[W])
            return MIN_V;
        else
            return MAX_V;
    endfunction

    always_comb begin
        state_d   = state_q;
        load_ok   = 1'b0;
        start_ok  = 1'b0;
        last_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                load_ok  = weight_load;
                start_ok = start && !weight_load;
                if (start_ok)
                    state_d = S_ACCUM;
            end
            S_ACCUM: begin
                last_step = (idx == LAST_IDX);
                if (last_step)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    assign busy = (state_q == S_ACCUM);

    // Weight bank shifts toward index 0, so the first loaded value ends in weight[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < n_inputs; i++)
                weight[i] <= '0;
        end else if (load_ok) begin
            for (int i = 0; i < n_inputs - 1; i++)
                weight[i] <= weight[i+1];
            weight[n_inputs-1] <= weight_in;
        end
    end

    assign term     = x_lat[idx] ? weight[idx] : '0;
    assign acc_next = sat_add(acc, term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_lat     <= '0;
            idx       <= '0;
            acc       <= '0;
            sum_wx    <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (start_ok) begin
                x_lat <= x;
                idx   <= '0;
                acc   <= '0;
            end else if (state_q == S_ACCUM) begin
                acc <= acc_next;
                idx <= idx + IW'(1);
                if (last_step) begin
                    sum_wx    <= acc_next;
                    sum_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/weighted_input_sum.md
# weighted_input_sum

Sequential synaptic front end of the LIF neuron. It holds a programmable bank of signed synaptic weights and, on request, accumulates the weights of all active input spikes into a saturated two's-complement sum. The sum is presented as `sum_wx` to the membrane-potential accumulator, which adds it to the decayed potential.

## Interface

Parameters:
- `n_stage`, default 6: datapath sizing. Data width W = n_stage+2 bits, matching the membrane accumulator operands.
- `n_inputs`, default 8: number of synaptic inputs and weights (≥2).

Ports:
- `clk`  input  1  clock. One clock; all state is updated on its rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `weight_load`  input  1  shift `weight_in` into the weight bank this cycle.
- `weight_in`  input  W  signed weight being shifted in.
- `start`  input  1  request one accumulation of input vector `x`.
- `x`  input  n_inputs  input spike vector, sampled only when `start` is accepted.
- `busy`  output  1  accumulation in progress.
- `sum_valid`  output  1  one-cycle pulse when `sum_wx` is updated.
- `sum_wx`  output  W  signed saturated sum of `weight[i]` over every i with `x[i]`=1.

## Operation

- Weight bank: n_inputs × W registers, `weight[0..n_inputs-1]`.
  - An accepted load shifts the bank down: `weight[i] <= weight[i+1]` and `weight[n_inputs-1] <= weight_in`.
  - After n_inputs loads, the first value loaded sits in `weight[0]`.
- FSM has two states.
  - IDLE, entered on reset.
    - `weight_load` is accepted only in IDLE.
    - `start` is accepted only in IDLE with `weight_load`=0. If both are high, the load is performed and `start` is dropped.
    - An accepted `start` latches `x` into an internal register, clears the accumulator and index, and moves to ACCUM.
  - ACCUM, one input per cycle for index i = 0..n_inputs-1:
    - `acc <= sat(acc + (x_lat[i] ? weight[i] : 0))`.
    - On i = n_inputs-1: `sum_wx` <= final sat result, `sum_valid` <= 1, then return to IDLE.
    - `start` and `weight_load` are ignored in ACCUM. Weights cannot change mid-accumulation.
- Arithmetic:
  - The addition is done at W+1 bits.
  - Results > 2^(W-1)-1 clamp to 2^(W-1)-1; results < -2^(W-1) clamp to -2^(W-1).
  - Saturation applies at every step, not only at the end.
- `sum_wx` holds its value between results. It is never cleared except by reset.
- Reset mid-operation: FSM returns to IDLE, accumulator cleared, `sum_valid`=0, no result is produced. The weight bank is also cleared to 0.
- Reset values: `busy`=0, `sum_valid`=0, `sum_wx`=0, all weights 0, index 0, latched x 0.

## Timing

- Edge T accepts `start`.
  - `busy`=1 from after edge T through edge T+n_inputs.
  - Edges T+1..T+n_inputs each process one input.
- At edge T+n_inputs: `sum_wx` updated, `sum_valid`=1 for exactly that one following cycle, `busy`=0.
- Latency from `start` to result: n_inputs cycles.
  - Throughput: one result per n_inputs cycles.
  - A new `start` is accepted in the same cycle `sum_valid` is high, giving back-to-back operation with no gap.
- `busy` and `sum_valid` are registered outputs and never high together.
- A weight load takes effect at the edge where it is sampled. A `start` in the next cycle uses the updated weight.

## Test plan

Parameters for all cases: n_stage=6 (W=8), n_inputs=8.

1. Reset: assert `rst_n`=0 mid-run, then release.
   - Required: `busy`=0, `sum_valid`=0, `sum_wx`=0 immediately, asynchronously.
   - Required: `start` with x=8'hFF yields `sum_wx`=0, since all weights are 0.
2. Load and full sum: load weights 1,2,...,8 (8 loads), then `start` with x=8'hFF.
   - Required: `busy` high for 8 cycles, then `sum_valid` pulses once with `sum_wx`=36.
   - Then x=8'b0000_0101: `sum_wx`=4 (w0+w2 = 1+3).
3. Saturation:
   - All weights 100, x=8'hFF: `sum_wx`=127.
   - All weights -100: `sum_wx`=-128 (8'h80).
   - Weights 100,100,-100,-100,0,0,0,0, x=8'h0F: `sum_wx`=-73. The intermediate clamps to 127, then 27, then -73, which proves per-step saturation.
4. Protocol:
   - `start` or `weight_load` pulsed while `busy`: ignored. Result unchanged, weights unchanged, no extra `sum_valid`.
   - `start` and `weight_load` together in IDLE: weight shifted, no accumulation begins.
5. Back-to-back: assert `start` in the cycle `sum_valid` is high, with a different x.
   - Required: second `sum_valid` exactly 8 cycles later with the correct second sum.
   - Required: first `sum_wx` held until then.
6. Reset mid-accumulation: drop `rst_n` 3 cycles after `start`.
   - Required: no `sum_valid` pulse, FSM in IDLE, weights 0.
   - Required: the next load and `start` behave as in scenario 2.
